// File: rtl/dds_cmd_sequencer_if.sv
// Host-side and SPI-side signal bundle for dds_cmd_sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface dds_cmd_sequencer_if #(
  parameter int FIFO_AW = 4
);
  logic [15:0]      wr_data;
  logic             wr_en;
  logic             flush;
  logic             err_clear;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FIFO_AW:0] fifo_level;
  logic [15:0]      dds_control;
  logic             dds_control_update;
  logic             spi_ready;
  logic             busy;
  logic [7:0]       dup_dropped;
  logic             err_overflow;
  logic             err_timeout;

  modport master (
    output wr_data, wr_en, flush, err_clear, spi_ready,
    input  fifo_full, fifo_empty, fifo_level, dds_control, dds_control_update,
           busy, dup_dropped, err_overflow, err_timeout
  );

  modport slave (
    input  wr_data, wr_en, flush, err_clear, spi_ready,
    output fifo_full, fifo_empty, fifo_level, dds_control, dds_control_update,
           busy, dup_dropped, err_overflow, err_timeout
  );
endinterface

// File: rtl/dds_cmd_sequencer.sv
// Feeds 16-bit DDS control words to the CW SPI stage one at a time from a FWFT FIFO,
// pacing on spi_ready, inserting a chip-select gap and dropping consecutive repeats.
module dds_cmd_sequencer #(
  parameter int FIFO_AW      = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  dds_cmd_sequencer_if.slave bus
);
  localparam int                 DEPTH    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [7:0]         TO_LAST  = 8'(BUSY_TIMEOUT - 1);
  localparam logic [7:0]         GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_t;

  state_t             r_state;
  logic [15:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_level;
  logic [15:0]        r_last_word;
  logic [15:0]        r_control;
  logic               r_update;
  logic               r_busy;
  logic [7:0]         r_dup;
  logic [7:0]         r_cnt;
  logic               r_err_ovf;
  logic               r_err_to;

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  logic               w_ovf_evt;
  logic               w_to_evt;
  logic [15:0]        w_head;

  assign w_full  = (r_level == LVL_FULL);
  assign w_empty = (r_level == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // A pop while full frees the slot the same clock, so the push is still accepted.
  assign w_pop     = (r_state == IDLE) && !w_empty && bus.spi_ready && !bus.flush;
  assign w_push    = bus.wr_en && !bus.flush && (!w_full || w_pop);
  assign w_ovf_evt = bus.wr_en && !bus.flush && w_full && !w_pop;
  assign w_to_evt  = (r_state == WAIT_BUSY) && bus.spi_ready && (r_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (bus.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // A new error event outranks err_clear in the same clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_ovf <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      if (w_ovf_evt)          r_err_ovf <= 1'b1;
      else if (bus.err_clear) r_err_ovf <= 1'b0;
      if (w_to_evt)           r_err_to  <= 1'b1;
      else if (bus.err_clear) r_err_to  <= 1'b0;
    end
  end

  // r_cnt counts clocks since the update strobe in WAIT_BUSY and gap clocks in GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_update    <= 1'b0;
      r_busy      <= 1'b0;
      r_dup       <= '0;
      r_cnt       <= '0;
      r_control   <= '0;
      r_last_word <= '0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            if (w_head == r_last_word) begin
              if (r_dup != 8'hFF) r_dup <= r_dup + 8'd1;
            end else begin
              r_control   <= w_head;
              r_last_word <= w_head;
              r_update    <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          r_cnt   <= 8'd1;
          r_state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!bus.spi_ready) begin
            r_state <= WAIT_DONE;
          end else if (r_cnt == TO_LAST) begin
            r_cnt   <= '0;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        WAIT_DONE: begin
          if (bus.spi_ready) begin
            r_cnt   <= '0;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (bus.flush || r_cnt == GAP_LAST) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.fifo_full          = w_full;
  assign bus.fifo_empty         = w_empty;
  assign bus.fifo_level         = r_level;
  assign bus.dds_control        = r_control;
  assign bus.dds_control_update = r_update;
  assign bus.busy               = r_busy;
  assign bus.dup_dropped        = r_dup;
  assign bus.err_overflow       = r_err_ovf;
  assign bus.err_timeout        = r_err_to;
endmodule

// File: tb/tb_dds_cmd_sequencer.sv
// Bench for dds_cmd_sequencer: FIFO fill/overflow vector table, directed corner
// sequences, and random bursts checked against a transaction-level dedup model.
module tb_dds_cmd_sequencer;
  localparam int AW  = 4;
  localparam int GAP = 4;
  localparam int BTO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dds_cmd_sequencer_if #(.FIFO_AW(AW)) bus ();

  dds_cmd_sequencer #(
    .FIFO_AW(AW), .GAP_CYCLES(GAP), .BUSY_TIMEOUT(BTO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic        flush;
    logic        err_clear;
    logic [15:0] data;
    logic [AW:0] exp_level;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_ovf;
  } vec_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          spi_mode = 1;     // 0: modelled SPI stage, 1: held low, 2: held high
  int          spi_low_len = 35;
  logic [15:0] got[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".level"},  32'(bus.fifo_level), 0);
    check({tag, ".empty"},  32'(bus.fifo_empty), 1);
    check({tag, ".full"},   32'(bus.fifo_full), 0);
    check({tag, ".ctrl"},   32'(bus.dds_control), 0);
    check({tag, ".upd"},    32'(bus.dds_control_update), 0);
    check({tag, ".busy"},   32'(bus.busy), 0);
    check({tag, ".dup"},    32'(bus.dup_dropped), 0);
    check({tag, ".ovf"},    32'(bus.err_overflow), 0);
    check({tag, ".to"},     32'(bus.err_timeout), 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    bus.err_clear = 1'b0;
    bus.wr_data = '0;
    repeat (2) @(negedge clk);
    check_reset(tag);
    rst = 1'b0;
    got.delete();
  endtask

  task automatic push(input logic [15:0] w);
    bus.wr_en = 1'b1;
    bus.wr_data = w;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.busy && bus.fifo_empty) begin ok = 1'b1; break; end
    end
    check({name, ".idle_reached"}, 32'(ok), 1);
  endtask

  task automatic wait_spi(input logic lvl, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (bus.spi_ready === lvl) begin ok = 1'b1; break; end
    end
    check({name, ".spi_edge_seen"}, 32'(ok), 1);
  endtask

  task automatic wait_strobe(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.dds_control_update) begin ok = 1'b1; break; end
    end
    check({name, ".strobe_seen"}, 32'(ok), 1);
  endtask

  task automatic compare_q(input string name, input logic [15:0] exp_q[$]);
    check({name, ".count"}, 32'(got.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < got.size()) check($sformatf("%s.word%0d", name, i), 32'(got[i]), 32'(exp_q[i]));
  endtask

  // SPI stage stand-in: records every strobe; ready falls 3 clks after it, rises spi_low_len later.
  initial begin
    int ph;
    ph = -1;
    bus.spi_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = -1;
      end else if (bus.dds_control_update) begin
        got.push_back(bus.dds_control);
        ph = 0;
      end else if (ph >= 0) begin
        ph++;
      end
      case (spi_mode)
        1:       bus.spi_ready = 1'b0;
        2:       bus.spi_ready = 1'b1;
        default: bus.spi_ready = !(ph >= 3 && ph < 3 + spi_low_len);
      endcase
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: time %0t reached, limit 600000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    vec_t        v;
    logic [15:0] exp_q[$];
    logic [15:0] alpha[4];
    logic [15:0] last;
    logic [15:0] w;
    int          exp_dup;
    int          n;

    bus.wr_en = 1'b0;
    bus.flush = 1'b0;
    bus.err_clear = 1'b0;
    bus.wr_data = '0;

    // ---- FIFO fill/overflow table with spi_ready held low ----
    spi_mode = 1;
    do_reset("reset0");
    for (int k = 0; k < 17; k++) begin
      v.wr_en = 1'b1; v.flush = 1'b0; v.err_clear = 1'b0;
      v.data = 16'(k + 1);
      v.exp_level = (AW + 1)'((k < 16) ? k + 1 : 16);
      v.exp_full = (k >= 15);
      v.exp_empty = 1'b0;
      v.exp_ovf = (k == 16);
      vecs.push_back(v);
    end
    v = '{wr_en: 1'b1, flush: 1'b0, err_clear: 1'b1, data: 16'h0099,
          exp_level: 5'd16, exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b1};
    vecs.push_back(v);
    v = '{wr_en: 1'b0, flush: 1'b0, err_clear: 1'b1, data: 16'h0000,
          exp_level: 5'd16, exp_full: 1'b1, exp_empty: 1'b0, exp_ovf: 1'b0};
    vecs.push_back(v);
    foreach (vecs[i]) begin
      bus.wr_en = vecs[i].wr_en;
      bus.flush = vecs[i].flush;
      bus.err_clear = vecs[i].err_clear;
      bus.wr_data = vecs[i].data;
      @(negedge clk);
      check($sformatf("vec%0d.level", i), 32'(bus.fifo_level), 32'(vecs[i].exp_level));
      check($sformatf("vec%0d.full", i),  32'(bus.fifo_full),  32'(vecs[i].exp_full));
      check($sformatf("vec%0d.empty", i), 32'(bus.fifo_empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d.ovf", i),   32'(bus.err_overflow), 32'(vecs[i].exp_ovf));
    end
    bus.wr_en = 1'b0; bus.flush = 1'b0; bus.err_clear = 1'b0;
    check("fill.no_issue_while_low", 32'(got.size()), 0);
    spi_low_len = 6;
    spi_mode = 0;
    wait_idle("fill.drain");
    exp_q.delete();
    for (int k = 0; k < 16; k++) exp_q.push_back(16'(k + 1));
    compare_q("fill.order", exp_q);

    // ---- single word: latency, hold, gap after ready returns ----
    spi_low_len = 35;
    do_reset("reset1");
    bus.wr_en = 1'b1; bus.wr_data = 16'h1234;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("t1.level_after_push", 32'(bus.fifo_level), 1);
    check("t1.no_early_strobe", 32'(bus.dds_control_update), 0);
    @(negedge clk);
    check("t1.strobe", 32'(bus.dds_control_update), 1);
    check("t1.word", 32'(bus.dds_control), 32'h1234);
    check("t1.busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("t1.strobe_one_clk", 32'(bus.dds_control_update), 0);
    check("t1.word_hold", 32'(bus.dds_control), 32'h1234);
    wait_spi(1'b0, "t1.fall");
    wait_spi(1'b1, "t1.rise");
    repeat (GAP) @(negedge clk);
    check("t1.busy_in_gap", 32'(bus.busy), 1);
    @(negedge clk);
    check("t1.busy_after_gap", 32'(bus.busy), 0);
    check("t1.word_hold_idle", 32'(bus.dds_control), 32'h1234);
    exp_q = '{16'h1234};
    compare_q("t1.strobes", exp_q);

    // ---- consecutive duplicate dropped ----
    do_reset("reset2");
    push(16'hAAAA); push(16'hAAAA); push(16'h5555);
    wait_idle("t2");
    exp_q = '{16'hAAAA, 16'h5555};
    compare_q("t2.strobes", exp_q);
    check("t2.dup", 32'(bus.dup_dropped), 1);

    // ---- spi_ready never falls: timeout, recovery, err_clear ----
    do_reset("reset3");
    spi_mode = 2;
    push(16'h0F0F);
    wait_strobe("t4");
    repeat (BTO - 1) @(negedge clk);
    check("t4.to_not_yet", 32'(bus.err_timeout), 0);
    @(negedge clk);
    check("t4.to_set", 32'(bus.err_timeout), 1);
    repeat (GAP - 1) @(negedge clk);
    check("t4.busy_gap", 32'(bus.busy), 1);
    @(negedge clk);
    check("t4.recovered", 32'(bus.busy), 0);
    check("t4.to_sticky", 32'(bus.err_timeout), 1);
    bus.err_clear = 1'b1;
    @(negedge clk);
    bus.err_clear = 1'b0;
    check("t4.to_cleared", 32'(bus.err_timeout), 0);
    spi_mode = 0;

    // ---- flush (with simultaneous wr_en) during WAIT_DONE ----
    do_reset("reset4");
    exp_q.delete();
    for (int k = 0; k < 5; k++) push(16'(16'h0101 + k));
    wait_spi(1'b0, "t5");
    repeat (2) @(negedge clk);
    check("t5.level_before", 32'(bus.fifo_level), 4);
    bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 16'hBEEF;
    @(negedge clk);
    bus.flush = 1'b0; bus.wr_en = 1'b0;
    check("t5.level_flushed", 32'(bus.fifo_level), 0);
    check("t5.busy_inflight", 32'(bus.busy), 1);
    wait_idle("t5");
    repeat (60) @(negedge clk);
    exp_q = '{16'h0101};
    compare_q("t5.strobes", exp_q);

    // ---- rst during WAIT_DONE with words queued ----
    do_reset("reset5");
    for (int k = 0; k < 4; k++) push(16'(16'h0201 + k));
    wait_spi(1'b0, "t6");
    repeat (2) @(negedge clk);
    check("t6.level_before", 32'(bus.fifo_level), 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset("t6.rst");
    rst = 1'b0;
    repeat (80) @(negedge clk);
    exp_q = '{16'h0201};
    compare_q("t6.strobes", exp_q);

    // ---- dup counter saturation ----
    do_reset("reset6");
    bus.wr_en = 1'b1; bus.wr_data = 16'h0000;
    repeat (260) @(negedge clk);
    bus.wr_en = 1'b0;
    wait_idle("sat");
    check("sat.dup", 32'(bus.dup_dropped), 255);
    check("sat.no_strobe", 32'(got.size()), 0);

    // ---- random bursts vs. dedup model ----
    do_reset("reset7");
    alpha = '{16'h0000, 16'h00A5, 16'h5A00, 16'hFFFF};
    exp_q.delete();
    last = 16'h0000;
    exp_dup = 0;
    for (int b = 0; b < 8; b++) begin
      spi_low_len = $urandom_range(1, 12);
      n = $urandom_range(1, 16);
      for (int j = 0; j < n; j++) begin
        w = alpha[$urandom_range(0, 3)];
        push(w);
        if (w == last) exp_dup++;
        else begin exp_q.push_back(w); last = w; end
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle($sformatf("rand%0d", b));
    end
    compare_q("rand.strobes", exp_q);
    check("rand.dup", 32'(bus.dup_dropped), 32'((exp_dup > 255) ? 255 : exp_dup));
    check("rand.no_errors", 32'({bus.err_overflow, bus.err_timeout}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
